// File: rtl/key_event_tx.sv
// key_event_tx: debounces the camera key bitmap and queues note-on/off bytes for the UART byte sender.
// Optional feature macro KEY_EVT_SNAPSHOT_EN: periodic 0xFF-headed snapshot of the stable key bitmap.
module key_event_tx #(
    parameter int NKEYS       = 40,
    parameter int DEBOUNCE    = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int SNAP_PERIOD = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NKEYS-1:0]            key_down,
    input  logic                        sample_en,
    output logic                        send,
    output logic [7:0]                  send_data,
    input  logic                        send_done,
    output logic [NKEYS-1:0]            stable_keys,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE, S_WAIT} tx_state_e;

    logic [NKEYS-1:0] stable_q, pending_q, pending_d, flip, cand, sel_oh;
    logic [3:0]       cnt_q [NKEYS];
    logic [3:0]       cnt_d [NKEYS];
    logic [5:0]       sel_idx;
    logic             sel_dir, sel_vld, push, pop, stall;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             fifo_full, fifo_empty;
    tx_state_e        state_q, state_d;
    logic             send_q, send_d;
    logic [7:0]       data_q, data_d;
    logic             tx_done, snap_busy;
    logic [7:0]       snap_byte;

    // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_en) begin
                if (key_down[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == 4'(DEBOUNCE - 1)) begin
                    cnt_d[i] = '0;
                    flip[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // A key flipping this cycle is skipped: its pending bit may be cancelling out.
    always_comb begin
        cand    = pending_q & ~flip;
        sel_oh  = '0;
        sel_idx = '0;
        sel_dir = 1'b0;
        sel_vld = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (cand[i] && !sel_vld) begin
                sel_oh[i] = 1'b1;
                sel_idx   = 6'(i);
                sel_dir   = stable_q[i];
                sel_vld   = 1'b1;
            end
        end
    end

    assign push      = sel_vld && !fifo_full && !stall;
    assign pending_d = (pending_q ^ flip) & ~(push ? sel_oh : '0);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
        end else begin
            stable_q  <= stable_q ^ flip;
            pending_q <= pending_d;
            for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign tx_done    = (state_q == S_WAIT) && send_done;
    assign pop        = tx_done && !snap_busy;

    // NOTE: the FIFO storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sel_dir, 1'b0, sel_idx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (snap_busy) begin
                    data_d  = snap_byte;
                    send_d  = 1'b1;
                    state_d = S_WAIT;
                end else if (!fifo_empty) begin
                    data_d  = mem_q[rd_ptr_q];
                    send_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (send_done) begin
                    send_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            data_q  <= data_d;
        end
    end

`ifdef KEY_EVT_SNAPSHOT_EN
    localparam int NBYTES = (NKEYS + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int SCW    = $clog2(SNAP_PERIOD + 1);

    logic [SCW-1:0] samp_cnt_q;
    logic           armed_q, busy_q;
    logic [3:0]     idx_q;
    logic [SW-1:0]  snap_keys_q;

    // The bitmap is frozen when the snapshot starts so all its bytes describe one instant.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_q  <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            snap_keys_q <= '0;
        end else begin
            if (armed_q && !busy_q && fifo_empty && pending_q == '0 && state_q == S_IDLE) begin
                armed_q     <= 1'b0;
                busy_q      <= 1'b1;
                idx_q       <= '0;
                snap_keys_q <= SW'(stable_q);
            end else if (busy_q && tx_done) begin
                if (idx_q == 4'(NBYTES)) busy_q <= 1'b0;
                idx_q <= idx_q + 4'd1;
            end
            if (sample_en) begin
                if (samp_cnt_q == SCW'(SNAP_PERIOD - 1)) begin
                    samp_cnt_q <= '0;
                    armed_q    <= 1'b1;
                end else begin
                    samp_cnt_q <= samp_cnt_q + SCW'(1);
                end
            end
        end
    end

    always_comb begin
        snap_byte = 8'hFF;
        if (idx_q != '0) snap_byte = snap_keys_q[(int'(idx_q) - 1) * 8 +: 8];
    end

    assign snap_busy = busy_q;
    assign stall     = busy_q;
`else
    assign snap_busy = 1'b0;
    assign stall     = 1'b0;
    assign snap_byte = 8'h00;
`endif

    assign send        = send_q;
    assign send_data   = data_q;
    assign stable_keys = stable_q;
    assign fifo_level  = count_q;
endmodule

// File: doc/key_event_tx.md
Name: key_event_tx

Overview:
- Sits between the camera key detector and the UART framing controller.
- Consumes the raw per-frame key_down[39:0] bitmap and debounces each key over consecutive camera frames.
- Turns stable key transitions into one-byte note-on/note-off events and queues them in a FIFO.
- Feeds the queued bytes to the UART byte sender with a send/send_done handshake; this replaces the periodic full-bitmap dump.

Parameters:
- NKEYS, 40, number of keys, 1..64.
- DEBOUNCE, 3, consecutive differing samples needed before a key's stable state flips, 1..15.
- FIFO_DEPTH, 16, event FIFO entries, power of 2.
- SNAP_PERIOD, 64, samples between snapshots; used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- key_down, input, NKEYS: raw key bitmap from the camera stage.
- sample_en, input, 1: one-cycle pulse once per camera frame; key_down is valid in that cycle.
- send, output, 1: byte request to the UART controller.
- send_data, output, 8: byte to transmit; held stable while send=1.
- send_done, input, 1: one-cycle pulse from the UART controller when the byte has been accepted.
- stable_keys, output, NKEYS: debounced key state.
- fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset: all outputs 0; all debounce counters, pending bits, FIFO pointers and the TX FSM go to their initial state (FIFO empty, TX in IDLE).
- Debounce, evaluated only in cycles where sample_en=1, per key i:
  - key_down[i]==stable[i]: cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] reaches DEBOUNCE: stable[i] toggles, cnt[i] clears, pending[i] toggles.
  - A second flip while pending[i] is still set clears pending[i]; the net change is none and no event is emitted.
  - With DEBOUNCE=1 the flip happens on the first differing sample.
- Event push:
  - Each cycle, the lowest-index set pending bit is selected and pushed as one byte {stable[i], 1'b0, i[5:0]}. Bit 7 = 1 means key pressed, 0 means released.
  - The push happens on the edge after the pending bit was set; pending[i] clears on that same edge.
  - One push per cycle at most.
  - FIFO full: no push and pending bits are held, so no event is ever dropped.
  - A pending bit being set by a sample in the same cycle as the push of a different key is allowed.
  - The push-select logic must exclude a bit that is toggling in the current cycle.
- FIFO: synchronous, first-word fall-through head; fifo_level is updated on the same edge as push or pop.
- TX FSM:
  - IDLE: when the FIFO is non-empty, load send_data with the head and set send=1 on the next edge, moving to WAIT.
  - WAIT: send and send_data hold. On send_done=1, pop the FIFO and drop send to 0 on the same edge, returning to IDLE.
  - send_done in IDLE is ignored.
  - Minimum spacing between two sends is one idle cycle.
- Latency: sample_en edge → stable update (edge 1) → FIFO push (edge 2) → send=1 (edge 3).
- Reset mid-transfer: send drops the next cycle; the FIFO and pending bits are flushed.

Optional Feature:
- Macro: KEY_EVT_SNAPSHOT_EN.
- When defined:
  - A sample counter wraps every SNAP_PERIOD sample_en pulses.
  - On wrap, a snapshot is armed. It is emitted when the FIFO is empty, pending==0 and TX is IDLE.
  - Snapshot bytes, in order: 0xFF, then ceil(NKEYS/8) bytes of stable_keys, LSB byte first, zero-padded. For NKEYS=40 that is 6 bytes total.
  - Snapshot bytes go through the same TX handshake. New pushes are stalled (pending held) until the last snapshot byte is done.
  - The 0xFF header cannot alias an event byte, because bit 6 of an event byte is always 0.
- When undefined: only event bytes are emitted and no sample counter exists.

Test Plan:
- Reset, then hold key_down=0 for 10 samples → send stays 0, fifo_level=0, stable_keys=0.
- key_down[5]=1 for 3 samples with DEBOUNCE=3 → stable_keys[5]=1 after the 3rd sample; send=1 with send_data=0x85 three clocks after that sample_en; a send_done pulse drops send the same edge.
- key_down[5]=1 for only 2 samples, then 0 → no flip, no byte sent.
- Keys 0, 7 and 39 rise together and hold → bytes 0x80, 0x87, 0xA7 in that order, with send_done returned 5 cycles after each send.
- Withhold send_done while 20 keys toggle → FIFO fills to 16 and the remaining 4 events stay pending; after releasing send_done all 20 bytes arrive, none lost or duplicated.
- With KEY_EVT_SNAPSHOT_EN, SNAP_PERIOD=4, keys 0 and 9 stable → after the 4th sample the bytes are 0xFF, 0x01, 0x02, 0x00, 0x00, 0x00.
